// File: rtl/syscall_unit_pkg.sv
// Shared constants, FSM state type and decode helper for the syscall service unit.
package syscall_unit_pkg;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] SYSCALL_FUNCT  = 6'h0C;

  localparam int unsigned SVC_PRINT_INT  = 1;
  localparam int unsigned SVC_PRINT_CHAR = 11;
  localparam int unsigned SVC_EXIT       = 10;
  localparam int unsigned SVC_EXIT2      = 17;

  typedef enum logic [1:0] {
    SC_RUN   = 2'd0,
    SC_DRAIN = 2'd1,
    SC_HALT  = 2'd2
  } sc_state_t;

  // True when a real fetch carries SYSCALL (SPECIAL opcode, funct 0x0C).
  function automatic logic is_syscall(input logic valid, input logic [31:0] instr);
    return valid && (instr[31:26] == OPCODE_SPECIAL) && (instr[5:0] == SYSCALL_FUNCT);
  endfunction

endpackage

// File: rtl/syscall_fifo.sv
// Output FIFO for print requests; head is read straight from registered storage.
module syscall_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers (wrap naturally) and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// MIPS syscall service unit: decode, run/drain/halt FSM, retired counter, output FIFO.
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_kind,
  output logic              stall,
  output logic              halted,
  output logic [DATA_W-1:0] exit_code,
  output logic              err_unknown,
  output logic [CNT_W-1:0]  sys_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sc_state_t         state;
  sc_state_t         next_state;

  logic              sys;
  logic              is_char;
  logic              is_print;
  logic              is_exit;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W:0]   fifo_din;
  logic [DATA_W:0]   fifo_dout;
  logic              count_en;
  logic              exit_en;
  logic              unknown;

  assign sys      = is_syscall(instr_valid, instruction);
  assign is_char  = (v0 == DATA_W'(SVC_PRINT_CHAR));
  assign is_print = (v0 == DATA_W'(SVC_PRINT_INT)) || is_char;
  assign is_exit  = (v0 == DATA_W'(SVC_EXIT)) || (v0 == DATA_W'(SVC_EXIT2));

  // Char payload is the low byte zero-extended; kind bit rides above the data.
  assign fifo_din = {is_char, is_char ? DATA_W'(a0[7:0]) : a0};
  assign fifo_pop = out_valid && out_ready;

  assign out_valid = !fifo_empty;
  assign out_kind  = fifo_dout[DATA_W];
  assign out_data  = fifo_dout[DATA_W-1:0];
  assign halted    = (state == SC_HALT);

  syscall_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SC_RUN;
    else          state <= next_state;
  end

  // Next state, stall and service strobes; full uses the registered count.
  always_comb begin
    next_state = state;
    fifo_push  = 1'b0;
    stall      = 1'b0;
    count_en   = 1'b0;
    exit_en    = 1'b0;
    unknown    = 1'b0;
    unique case (state)
      SC_RUN: begin
        if (sys) begin
          if (is_print) begin
            if (fifo_full) begin
              stall = 1'b1;
            end else begin
              fifo_push = 1'b1;
              count_en  = 1'b1;
            end
          end else if (is_exit) begin
            exit_en    = 1'b1;
            count_en   = 1'b1;
            stall      = 1'b1;
            next_state = SC_DRAIN;
          end else begin
            unknown  = 1'b1;
            count_en = 1'b1;
          end
        end
      end
      SC_DRAIN: begin
        stall = 1'b1;
        if (fifo_count == '0) next_state = SC_HALT;
      end
      SC_HALT: begin
        stall = 1'b1;
      end
      default: next_state = SC_RUN;
    endcase
  end

  // Exit code latch, unknown-service pulse and saturating retired counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exit_code   <= '0;
      err_unknown <= 1'b0;
      sys_count   <= '0;
    end else begin
      if (exit_en) exit_code <= (v0 == DATA_W'(SVC_EXIT)) ? '0 : a0;
      err_unknown <= unknown;
      if (count_en && (sys_count != '1)) sys_count <= sys_count + 1'b1;
    end
  end

endmodule
